// File: rtl/acl_pkg.sv
// Shared constants and state encoding for the ADXL362 register-interface emulator.
package acl_pkg;

  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;

  localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [5:0] ADDR_PARTID    = 6'h02;
  localparam logic [5:0] ADDR_XDATA     = 6'h08;
  localparam logic [5:0] ADDR_YDATA     = 6'h09;
  localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
  localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
  localparam logic [5:0] ADDR_FILTER    = 6'h2C;
  localparam logic [5:0] ADDR_POWER     = 6'h2D;

  localparam logic [7:0] FILTER_CTL_RST = 8'h13;
  localparam logic [1:0] MEASURE_MODE   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } spi_state_e;

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes the SPI pins into the system clock domain and derives
// single-cycle sclk rise/fall and csn fall pulses.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic csn_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic csn_fall_o,
  output logic csn_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   csn_prev_q;

  // csn resets deasserted so a select held low through reset still yields a fall pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_o = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
  assign csn_fall_o  = ~csn_sync_q[SYNC_STAGES-1] & csn_prev_q;
  assign csn_o       = csn_sync_q[SYNC_STAGES-1];
  assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-0 slave emulating the ADXL362 register interface: read/write
// commands with auto-increment, X/Y/Z snapshot taken at chip-select fall.
module acl_spi_responder
  import acl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  DEVID_MST   = 8'h1D,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        sclk,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  input  logic [11:0] x_data,
  input  logic [11:0] y_data,
  input  logic [11:0] z_data,
  output logic        measure_en,
  output logic        busy,
  output logic        wr_strobe
);

  logic sclk_rise, sclk_fall, csn_fall, csn_s, mosi_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .sclk_i     (sclk),
    .csn_i      (csn),
    .mosi_i     (mosi),
    .sclk_rise_o(sclk_rise),
    .sclk_fall_o(sclk_fall),
    .csn_fall_o (csn_fall),
    .csn_o      (csn_s),
    .mosi_o     (mosi_s)
  );

  spi_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_in_q, shift_in_d;
  logic        is_wr_q, is_wr_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [7:0]  sout_q, sout_d;
  logic        miso_q, miso_d;
  logic [7:0]  power_q, power_d;
  logic [7:0]  filter_q, filter_d;
  logic [15:0] snap_x_q, snap_x_d;
  logic [15:0] snap_y_q, snap_y_d;
  logic [15:0] snap_z_q, snap_z_d;
  logic        busy_q, busy_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        measure_q, measure_d;

  logic [7:0]  byte_in;
  logic [5:0]  ptr_inc;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;

  assign byte_in = {shift_in_q[6:0], mosi_s};
  assign ptr_inc = ptr_q + 6'd1;

  // The shift-out register is always loaded with the byte for the *next* data
  // phase: the incoming address at the end of ADDR, else the incremented pointer.
  always_comb begin
    rd_addr = (state_q == ST_ADDR) ? byte_in[5:0] : ptr_inc;
    case (rd_addr)
      ADDR_DEVID_AD:  rd_data = DEVID_AD;
      ADDR_DEVID_MST: rd_data = DEVID_MST;
      ADDR_PARTID:    rd_data = PARTID;
      ADDR_XDATA:     rd_data = snap_x_q[11:4];
      ADDR_YDATA:     rd_data = snap_y_q[11:4];
      ADDR_ZDATA:     rd_data = snap_z_q[11:4];
      ADDR_XDATA_L:   rd_data = snap_x_q[7:0];
      ADDR_XDATA_H:   rd_data = snap_x_q[15:8];
      ADDR_YDATA_L:   rd_data = snap_y_q[7:0];
      ADDR_YDATA_H:   rd_data = snap_y_q[15:8];
      ADDR_ZDATA_L:   rd_data = snap_z_q[7:0];
      ADDR_ZDATA_H:   rd_data = snap_z_q[15:8];
      ADDR_FILTER:    rd_data = filter_q;
      ADDR_POWER:     rd_data = power_q;
      default:        rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    is_wr_d     = is_wr_q;
    ptr_d       = ptr_q;
    sout_d      = sout_q;
    miso_d      = miso_q;
    power_d     = power_q;
    filter_d    = filter_q;
    snap_x_d    = snap_x_q;
    snap_y_d    = snap_y_q;
    snap_z_d    = snap_z_q;
    wr_strobe_d = 1'b0;
    busy_d      = ~csn_s;
    measure_d   = (power_q[1:0] == MEASURE_MODE);

    if (csn_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (csn_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = '0;
        snap_x_d  = sext12(x_data);
        snap_y_d  = sext12(y_data);
        snap_z_d  = sext12(z_data);
      end
    end else begin
      if (sclk_rise) begin
        shift_in_d = byte_in;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              if (byte_in == CMD_WR || byte_in == CMD_RD) begin
                state_d = ST_ADDR;
                is_wr_d = (byte_in == CMD_WR);
              end else begin
                state_d = ST_IGNORE;
              end
            end
            ST_ADDR: begin
              state_d = ST_DATA;
              ptr_d   = byte_in[5:0];
              sout_d  = rd_data;
            end
            ST_DATA: begin
              if (is_wr_q) begin
                if (ptr_q == ADDR_FILTER) begin
                  filter_d    = byte_in;
                  wr_strobe_d = 1'b1;
                end else if (ptr_q == ADDR_POWER) begin
                  power_d     = byte_in;
                  wr_strobe_d = 1'b1;
                end
              end
              ptr_d  = ptr_inc;
              sout_d = rd_data;
            end
            default: ;
          endcase
        end
      end
      if (sclk_fall) begin
        if (state_q == ST_DATA) begin
          miso_d = sout_q[7];
          sout_d = {sout_q[6:0], 1'b0};
        end else begin
          miso_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      is_wr_q     <= 1'b0;
      ptr_q       <= '0;
      sout_q      <= '0;
      miso_q      <= 1'b0;
      power_q     <= '0;
      filter_q    <= FILTER_CTL_RST;
      snap_x_q    <= '0;
      snap_y_q    <= '0;
      snap_z_q    <= '0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      measure_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      is_wr_q     <= is_wr_d;
      ptr_q       <= ptr_d;
      sout_q      <= sout_d;
      miso_q      <= miso_d;
      power_q     <= power_d;
      filter_q    <= filter_d;
      snap_x_q    <= snap_x_d;
      snap_y_q    <= snap_y_d;
      snap_z_q    <= snap_z_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      measure_q   <= measure_d;
    end
  end

  assign miso       = miso_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign measure_en = measure_q;

endmodule

// File: tb/tb_acl_spi_responder.sv
// Bench for acl_spi_responder: SPI master driver, register-map reference
// model feeding a scoreboard, and a monitor for miso bytes and strobes.
module tb_acl_spi_responder;

  localparam int unsigned HALF = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic       chk;
    logic [7:0] val;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        sclk = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [11:0] x_data = '0;
  logic [11:0] y_data = '0;
  logic [11:0] z_data = '0;
  logic        measure_en;
  logic        busy;
  logic        wr_strobe;

  acl_spi_responder #(
    .SYNC_STAGES(2),
    .DEVID_AD   (8'hAD),
    .DEVID_MST  (8'h1D),
    .PARTID     (8'hF2)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .sclk      (sclk),
    .csn       (csn),
    .mosi      (mosi),
    .miso      (miso),
    .x_data    (x_data),
    .y_data    (y_data),
    .z_data    (z_data),
    .measure_en(measure_en),
    .busy      (busy),
    .wr_strobe (wr_strobe)
  );

  always #5 Clk = ~Clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  exp_t        exp_q[$];
  logic [7:0]  rx_byte;
  event        rx_ev;
  int unsigned wr_cnt = 0;

  // reference model state
  int          m_x, m_y, m_z;
  logic [7:0]  m_pc = 8'h00;
  logic [7:0]  m_fc = 8'h13;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic int to_signed12(input logic [11:0] v);
    int r;
    r = int'(v);
    if (r >= 2048) r = r - 4096;
    return r;
  endfunction

  function automatic logic [7:0] model_read(input int unsigned a);
    case (a)
      'h00: return 8'hAD;
      'h01: return 8'h1D;
      'h02: return 8'hF2;
      'h08: return 8'((m_x >>> 4) & 255);
      'h09: return 8'((m_y >>> 4) & 255);
      'h0A: return 8'((m_z >>> 4) & 255);
      'h0E: return 8'(m_x & 255);
      'h0F: return 8'((m_x >>> 8) & 255);
      'h10: return 8'(m_y & 255);
      'h11: return 8'((m_y >>> 8) & 255);
      'h12: return 8'(m_z & 255);
      'h13: return 8'((m_z >>> 8) & 255);
      'h2C: return m_fc;
      'h2D: return m_pc;
      default: return 8'h00;
    endcase
  endfunction

  // Only fully shifted bytes have any effect; a trailing partial byte is dropped.
  task automatic model_txn(input bq_t tx, input int unsigned nbits, output int unsigned n_wr);
    int unsigned nfull;
    int unsigned a;
    exp_t e;
    n_wr  = 0;
    nfull = nbits / 8;
    for (int unsigned i = 0; i < nfull; i++) begin
      e.chk = 1'b1;
      e.val = 8'h00;
      if (i >= 2 && (tx[0] == 8'h0A || tx[0] == 8'h0B)) begin
        a = ((int'(tx[1]) % 64) + (i - 2)) % 64;
        if (tx[0] == 8'h0B) begin
          e.val = model_read(a);
        end else begin
          e.chk = 1'b0;
          if (a == 'h2C) begin m_fc = tx[i]; n_wr++; end
          if (a == 'h2D) begin m_pc = tx[i]; n_wr++; end
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic spi_txn(input bq_t tx, input int unsigned nbits, input bit rst_abort);
    logic [7:0] rx;
    logic [7:0] cur;
    rx   = '0;
    sclk = 1'b0;
    csn  = 1'b0;
    repeat (HALF) @(negedge Clk);
    check("busy_active", busy, 1'b1);
    for (int unsigned b = 0; b < nbits; b++) begin
      cur  = tx[b / 8];
      mosi = cur[7 - (b % 8)];
      repeat (HALF) @(negedge Clk);
      rx   = {rx[6:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge Clk);
      sclk = 1'b0;
      if (b % 8 == 7) begin
        rx_byte = rx;
        ->rx_ev;
      end
    end
    repeat (HALF) @(negedge Clk);
    if (rst_abort) begin
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      check("miso_in_reset", miso, 1'b0);
      csn = 1'b1;
      repeat (4) @(negedge Clk);
      Reset = 1'b0;
    end else begin
      csn = 1'b1;
    end
    repeat (6) @(negedge Clk);
    check("busy_idle", busy, 1'b0);
    check("miso_idle", miso, 1'b0);
  endtask

  task automatic do_txn(input bq_t tx, input int unsigned nbits, input bit rst_abort);
    int unsigned n_wr;
    int unsigned wr0;
    m_x = to_signed12(x_data);
    m_y = to_signed12(y_data);
    m_z = to_signed12(z_data);
    model_txn(tx, nbits, n_wr);
    if (rst_abort) begin
      m_pc = 8'h00;
      m_fc = 8'h13;
    end
    wr0 = wr_cnt;
    spi_txn(tx, nbits, rst_abort);
    check("wr_strobe_count", wr_cnt - wr0, n_wr);
    check("measure_en", measure_en, m_pc[1:0] == 2'b10);
  endtask

  task automatic txn(input bq_t tx);
    do_txn(tx, tx.size() * 8, 1'b0);
  endtask

  // scoreboard: one expected entry per completed byte on the wire
  initial begin
    exp_t e;
    forever begin
      @(rx_ev);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL miso_byte: got 0x%0h with no expected entry", rx_byte);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check("miso_byte", rx_byte, e.val);
      end
    end
  end

  // strobe counting and measure_en latency relative to the committing write
  int unsigned cyc = 0;
  int unsigned last_strobe = 0;
  logic        prev_me = 1'b0;
  logic        prev_rst = 1'b1;
  always @(negedge Clk) begin
    cyc++;
    if (wr_strobe === 1'b1) begin
      wr_cnt++;
      last_strobe = cyc;
    end
    if (measure_en !== prev_me && !Reset && !prev_rst)
      check("measure_en_latency", cyc - last_strobe, 1);
    prev_me  = measure_en;
    prev_rst = Reset;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t tx;
    int unsigned r, len;
    logic [7:0] a, c;
    logic [5:0] picks [16];
    picks = '{6'h00, 6'h01, 6'h02, 6'h08, 6'h09, 6'h0A, 6'h0E, 6'h0F,
              6'h10, 6'h11, 6'h12, 6'h13, 6'h2C, 6'h2D, 6'h3F, 6'h20};

    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_miso", miso, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_measure_en", measure_en, 1'b0);

    txn('{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00});

    x_data = 12'hFF8; y_data = 12'h005; z_data = 12'h7FF;
    txn('{8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

    txn('{8'h0A, 8'h2D, 8'h02});
    txn('{8'h0B, 8'h2D, 8'h00});

    x_data = 12'h123;
    fork
      txn('{8'h0B, 8'h0E, 8'h00, 8'h00});
      begin
        repeat (200) @(negedge Clk);
        x_data = 12'hABC;
      end
    join

    txn('{8'h55, 8'h0B, 8'h2D, 8'h00});
    txn('{8'h0A, 8'h00, 8'h55});
    txn('{8'h0B, 8'h00, 8'h00});

    do_txn('{8'h0A, 8'h2D, 8'h01}, 20, 1'b0);
    txn('{8'h0B, 8'h2D, 8'h00});

    txn('{8'h0A, 8'h2C, 8'h5A});
    do_txn('{8'h0B, 8'h2C, 8'h00, 8'h00}, 28, 1'b1);
    txn('{8'h0B, 8'h2C, 8'h00, 8'h00});

    txn('{8'h0B, 8'h3F, 8'h00, 8'h00, 8'h00});
    txn('{8'h0B, 8'hC0, 8'h00});

    for (int k = 0; k < 30; k++) begin
      x_data = 12'($urandom_range(0, 4095));
      y_data = 12'($urandom_range(0, 4095));
      z_data = 12'($urandom_range(0, 4095));
      r   = $urandom_range(0, 9);
      a   = {2'($urandom_range(0, 3)), picks[$urandom_range(0, 15)]};
      len = $urandom_range(0, 4);
      if (r <= 4) c = 8'h0B;
      else if (r <= 7) c = 8'h0A;
      else begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'h0A || c == 8'h0B) c = c ^ 8'h80;
      end
      tx = '{c, a};
      for (int unsigned j = 0; j < len; j++) tx.push_back(8'($urandom_range(0, 255)));
      txn(tx);
    end

    repeat (20) @(negedge Clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
